// File: rtl/switch_box_cfg.sv
// switch_box_cfg: four-sided routing switch box with W tracks per side, configured over
// a serial shadow chain and committed atomically into the active configuration.
module switch_box_cfg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] n_in,
  input  logic [W-1:0] e_in,
  input  logic [W-1:0] s_in,
  input  logic [W-1:0] w_in,
  output logic [W-1:0] n_out,
  output logic [W-1:0] e_out,
  output logic [W-1:0] s_out,
  output logic [W-1:0] w_out,
  input  logic         cfg_en,
  input  logic         cfg_in,
  output logic         cfg_out,
  input  logic         cfg_commit,
  output logic         cfg_loaded
);

  localparam int CFG_BITS = 12 * W;
  localparam int CNT_W    = $clog2(CFG_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CFG_BITS);

  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] active;
  logic [CNT_W-1:0]    cnt;

  logic [3:0][W-1:0] din;
  logic [3:0][W-1:0] sel_val;
  logic [3:0][W-1:0] oreg;
  logic [3:0][W-1:0] dout;

  // Commit reads the pre-edge shadow, so a concurrent shift never leaks into active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      cnt    <= '0;
    end else begin
      if (cfg_en)
        shadow <= {shadow[CFG_BITS-2:0], cfg_in};
      if (cfg_commit)
        active <= shadow;
      if (cfg_commit)
        cnt <= cfg_en ? CNT_W'(1) : '0;
      else if (cfg_en && (cnt != CNT_MAX))
        cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      oreg <= '0;
    else
      oreg <= sel_val;
  end

  assign din = {w_in, s_in, e_in, n_in};

  // Side index order N=0, E=1, S=2, W=3 makes opposite/next/previous simple mod-4 offsets.
  for (genvar s = 0; s < 4; s++) begin : g_side
    for (genvar i = 0; i < W; i++) begin : g_track
      localparam int BASE  = (s * W + i) * 3;
      localparam int OPP   = (s + 2) % 4;
      localparam int NEXT  = (s + 1) % 4;
      localparam int PREV  = (s + 3) % 4;
      localparam int TWIST = (i + 1) % W;

      logic [1:0] sel;
      assign sel = active[BASE+1:BASE];

      assign sel_val[s][i] = (sel == 2'b01) ? din[OPP][i]  :
                             (sel == 2'b10) ? din[NEXT][i] :
                             (sel == 2'b11) ? din[PREV][TWIST] : 1'b0;

      assign dout[s][i] = active[BASE+2] ? oreg[s][i] : sel_val[s][i];
    end
  end

  assign n_out = dout[0];
  assign e_out = dout[1];
  assign s_out = dout[2];
  assign w_out = dout[3];

  assign cfg_out    = shadow[CFG_BITS-1];
  assign cfg_loaded = (cnt == CNT_MAX);

endmodule

// File: tb/tb_switch_box_cfg.sv
// tb_switch_box_cfg: directed, table-driven bench for switch_box_cfg with W=2 (24-bit chain).
module tb_switch_box_cfg;

  localparam int W  = 2;
  localparam int CB = 12 * W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] n_in, e_in, s_in, w_in;
  logic [W-1:0] n_out, e_out, s_out, w_out;
  logic         cfg_en, cfg_in, cfg_out, cfg_commit, cfg_loaded;

  int checks = 0;
  int fails  = 0;

  // Config exercising every selector kind: N0<-s0, N1<-e1, E0<-n1, E1<-w1, S0<-w0, S1<-e0, W0<-e0, W1 off.
  localparam logic [CB-1:0] CFG_MIX  = 24'b000_001_011_010_001_011_010_001;
  localparam logic [CB-1:0] CFG_N0   = 24'h000001;
  localparam logic [CB-1:0] CFG_TWR  = 24'hE00000;
  localparam logic [CB-1:0] PATTERN  = 24'hA53C96;

  typedef struct {
    logic [7:0] ins;
    logic [7:0] outs;
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  switch_box_cfg #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .n_in       (n_in),
    .e_in       (e_in),
    .s_in       (s_in),
    .w_in       (w_in),
    .n_out      (n_out),
    .e_out      (e_out),
    .s_out      (s_out),
    .w_out      (w_out),
    .cfg_en     (cfg_en),
    .cfg_in     (cfg_in),
    .cfg_out    (cfg_out),
    .cfg_commit (cfg_commit),
    .cfg_loaded (cfg_loaded)
  );

  function automatic logic [7:0] dutOuts();
    return {n_out, e_out, s_out, w_out};
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Inputs packed as {n,e,s,w}, changed mid-cycle away from the rising edge.
  task automatic applyStimulus(input logic [7:0] v);
    @(negedge clk);
    {n_in, e_in, s_in, w_in} = v;
    #1;
  endtask

  task automatic shiftBit(input logic b, input logic commit);
    @(negedge clk);
    cfg_en     = 1'b1;
    cfg_in     = b;
    cfg_commit = commit;
    @(posedge clk);
    #1;
    cfg_en     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic shiftWord(input logic [CB-1:0] c);
    for (int k = CB - 1; k >= 0; k--)
      shiftBit(c[k], 1'b0);
  endtask

  task automatic doCommit();
    @(negedge clk);
    cfg_commit = 1'b1;
    @(posedge clk);
    #1;
    cfg_commit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{8'h00, 8'h00};
    vecs[1] = '{8'h04, 8'h40};
    vecs[2] = '{8'h20, 8'h80};
    vecs[3] = '{8'h10, 8'h09};
    vecs[4] = '{8'h80, 8'h10};
    vecs[5] = '{8'h40, 8'h00};
    vecs[6] = '{8'h02, 8'h20};
    vecs[7] = '{8'h01, 8'h04};
    vecs[8] = '{8'hFF, 8'hFD};
    vecs[9] = '{8'hF0, 8'h99};

    // Reset with noisy inputs and an active shift enable.
    rst_n      = 1'b1;
    cfg_commit = 1'b0;
    cfg_en     = 1'b1;
    cfg_in     = 1'b1;
    {n_in, e_in, s_in, w_in} = 8'($urandom);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("reset_outs", dutOuts(), 8'h00);
    checkOutput("reset_cfg_out", 8'(cfg_out), 8'h00);
    checkOutput("reset_loaded", 8'(cfg_loaded), 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_held_outs", dutOuts(), 8'h00);
    @(negedge clk);
    cfg_en = 1'b0;
    cfg_in = 1'b0;
    rst_n  = 1'b1;

    // Combinational route N0 <- s_in[0].
    shiftWord(CFG_N0);
    checkOutput("comb_loaded_before_commit", 8'(cfg_loaded), 8'h01);
    doCommit();
    checkOutput("comb_loaded_after_commit", 8'(cfg_loaded), 8'h00);
    applyStimulus(8'h04);
    checkOutput("comb_route", dutOuts(), 8'h40);

    // Twisted registered route W1 <- s_in[0] with one-edge latency.
    shiftWord(CFG_TWR);
    doCommit();
    applyStimulus(8'h00);
    @(posedge clk);
    #1;
    checkOutput("twist_idle", dutOuts(), 8'h00);
    applyStimulus(8'h04);
    checkOutput("twist_before_edge", dutOuts(), 8'h00);
    @(posedge clk);
    #1;
    checkOutput("twist_after_edge", dutOuts(), 8'h02);
    applyStimulus(8'h00);
    checkOutput("twist_fall_before_edge", dutOuts(), 8'h02);
    @(posedge clk);
    #1;
    checkOutput("twist_fall_after_edge", dutOuts(), 8'h00);

    // Shadow isolation: loading a new pattern must not disturb the live route.
    applyStimulus(8'h04);
    shiftWord(CFG_MIX);
    checkOutput("shadow_isolated", dutOuts(), 8'h02);
    checkOutput("shadow_loaded", 8'(cfg_loaded), 8'h01);
    doCommit();
    checkOutput("shadow_commit_outs", dutOuts(), 8'h40);
    checkOutput("shadow_commit_loaded", 8'(cfg_loaded), 8'h00);

    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].ins);
      checkOutput($sformatf("table_vec%0d", v), dutOuts(), vecs[v].outs);
    end

    // Simultaneous shift and commit: active takes the pre-shift shadow, counter restarts at 1.
    shiftWord(CFG_N0);
    checkOutput("simul_pre_loaded", 8'(cfg_loaded), 8'h01);
    applyStimulus(8'h04);
    shiftBit(PATTERN[CB-1], 1'b1);
    checkOutput("simul_active_pre_shift", dutOuts(), 8'h40);
    checkOutput("simul_loaded_cleared", 8'(cfg_loaded), 8'h00);
    for (int k = CB - 2; k >= 1; k--)
      shiftBit(PATTERN[k], 1'b0);
    checkOutput("simul_count_23", 8'(cfg_loaded), 8'h00);
    shiftBit(PATTERN[0], 1'b0);
    checkOutput("simul_count_24", 8'(cfg_loaded), 8'h01);
    checkOutput("chain_replay_first", 8'(cfg_out), 8'(PATTERN[CB-1]));
    for (int j = 0; j < 8; j++) begin
      shiftBit(1'b0, 1'b0);
      checkOutput($sformatf("chain_replay_%0d", j), 8'(cfg_out), 8'(PATTERN[CB-2-j]));
    end
    checkOutput("chain_outs_unchanged", dutOuts(), 8'h40);

    // Asynchronous reset in the middle of a load.
    for (int k = CB - 1; k >= CB - 10; k--)
      shiftBit(CFG_MIX[k], 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midload_reset_outs", dutOuts(), 8'h00);
    checkOutput("midload_reset_cfg_out", 8'(cfg_out), 8'h00);
    checkOutput("midload_reset_loaded", 8'(cfg_loaded), 8'h00);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("midload_active_cleared", dutOuts(), 8'h00);
    for (int k = CB - 1; k >= 1; k--)
      shiftBit(CFG_MIX[k], 1'b0);
    checkOutput("midload_count_23", 8'(cfg_loaded), 8'h00);
    shiftBit(CFG_MIX[0], 1'b0);
    checkOutput("midload_count_24", 8'(cfg_loaded), 8'h01);
    doCommit();
    applyStimulus(vecs[8].ins);
    checkOutput("midload_reload_route", dutOuts(), vecs[8].outs);
    applyStimulus(vecs[9].ins);
    checkOutput("midload_reload_route2", dutOuts(), vecs[9].outs);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
